red_filter_cfg_sched: RTL and testbench

Register-access scheduler for the red filter IP's AXI4-Lite slave (four 32-bit registers at offsets 0x0, 0x4, 0x8, 0xC). Two requesters (req0: software shadow path, req1: reconfiguration manager) submit single-register read or write commands. The block arbitrates between them round-robin and sequences each command as one AXI4-Lite transaction on its master port. It returns read data and response status to the granted requester.

---
 rtl/red_filter_cfg_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_red_filter_cfg_sched.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_filter_cfg_sched.sv
// -----------------------------------------------------------------------------
// red_filter_cfg_sched
//
// Register-access scheduler for the red filter AXI4-Lite slave. Two requesters
// (req0: software shadow path, req1: reconfiguration manager) submit single
// register read/write commands. Commands are granted round-robin and each one
// is carried out as exactly one AXI4-Lite transaction on the master port.
// Read data and response status are returned to the granted requester.
//
// Optional feature macro: RED_FILTER_CFG_SCHED_READBACK_EN
//   When defined, every write is followed by a read of the same address. The
//   write completion then carries the read-back value, and err also flags a
//   read-back value that differs from the written data.
//
// Ports
//   ACLK, ARESET             clock (rising edge), synchronous active-high reset
//   reqN_valid/write/reg/wdata  command from requester N (N = 0,1)
//   reqN_ready               one-cycle accept pulse
//   reqN_done                one-cycle completion pulse
//   reqN_rdata, reqN_err     read data and error flag, valid with done
//   M_AXI_*                  AXI4-Lite master (AW, W, B, AR, R channels)
// -----------------------------------------------------------------------------
module red_filter_cfg_sched #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic                            req0_valid,
    input  logic                            req0_write,
    input  logic [1:0]                      req0_reg,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
    output logic                            req0_ready,
    output logic                            req0_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
    output logic                            req0_err,

    input  logic                            req1_valid,
    input  logic                            req1_write,
    input  logic [1:0]                      req1_reg,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
    output logic                            req1_ready,
    output logic                            req1_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
    output logic                            req1_err,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
        RB_REQ  = 3'd5,
        RB_RESP = 3'd6,
`endif
        DONE    = 3'd7
    } state_t;

    state_t                          state_q, state_d;
    logic                            last_grant;   // requester granted most recently
    logic                            cur_grant;    // requester owning the current command
    logic                            grant_sel;
    logic                            accept;
    logic                            sel_write;
    logic [1:0]                      sel_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0]   sel_wdata;
    logic                            is_write;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   cap_data;
    logic                            cap_err;
    logic                            aw_done;      // AW handshake already seen for this write
    logic                            w_done;       // W handshake already seen for this write

    // Round-robin: on a tie the requester not granted last time wins; a lone
    // requester is always granted.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        grant_sel = 1'b0;
        if (req0_valid && req1_valid)
            grant_sel = ~last_grant;
        else if (req1_valid)
            grant_sel = 1'b1;
    end

    // Gating with ARESET keeps the accept pulse from appearing while the
    // reset is holding the FSM in IDLE.
    assign accept    = (state_q == IDLE) && (req0_valid || req1_valid) && !ARESET;
    assign sel_write = grant_sel ? req1_write : req0_write;
    assign sel_reg   = grant_sel ? req1_reg   : req0_reg;
    assign sel_wdata = grant_sel ? req1_wdata : req0_wdata;

    // State register
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (ARESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = sel_write ? WR_REQ : RD_REQ;
            // AW and W may complete in the same cycle or in different ones.
            WR_REQ:  if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                         state_d = WR_RESP;
`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
            WR_RESP: if (M_AXI_BVALID) state_d = RB_REQ;
            RB_REQ:  if (M_AXI_ARREADY) state_d = RB_RESP;
            RB_RESP: if (M_AXI_RVALID) state_d = DONE;
`else
            WR_RESP: if (M_AXI_BVALID) state_d = DONE;
`endif
            RD_REQ:  if (M_AXI_ARREADY) state_d = RD_RESP;
            RD_RESP: if (M_AXI_RVALID) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, handshake tracking and response capture
    always_ff @(posedge ACLK) begin
        // NOTE: these registers drive ports directly, so they are reset to
        // give the outputs defined values out of reset.
        if (ARESET) begin
            last_grant <= 1'b1;
            cur_grant  <= 1'b0;
            is_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_data   <= '0;
            cap_err    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    last_grant <= grant_sel;
                    cur_grant  <= grant_sel;
                    is_write   <= sel_write;
                    addr_q     <= C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({sel_reg, 2'b00});
                    wdata_q    <= sel_wdata;
                    cap_data   <= '0;
                    cap_err    <= 1'b0;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                end
                WR_REQ: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
                    if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
                end
                WR_RESP: if (M_AXI_BVALID) cap_err <= (M_AXI_BRESP != 2'b00);
                RD_RESP: if (M_AXI_RVALID) begin
                    cap_data <= M_AXI_RDATA;
                    cap_err  <= (M_AXI_RRESP != 2'b00);
                end
`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
                // Keep any write-response error and add read-back failures.
                RB_RESP: if (M_AXI_RVALID) begin
                    cap_data <= M_AXI_RDATA;
                    cap_err  <= cap_err || (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != wdata_q);
                end
`endif
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        M_AXI_AWADDR  = addr_q;
        M_AXI_ARADDR  = addr_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_AWPROT  = 3'b000;
        M_AXI_ARPROT  = 3'b000;
        M_AXI_WSTRB   = '1;
        M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done;
        M_AXI_WVALID  = (state_q == WR_REQ) && !w_done;
        M_AXI_BREADY  = (state_q == WR_RESP);
        M_AXI_ARVALID = (state_q == RD_REQ);
        M_AXI_RREADY  = (state_q == RD_RESP);
`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
        M_AXI_ARVALID = M_AXI_ARVALID || (state_q == RB_REQ);
        M_AXI_RREADY  = M_AXI_RREADY  || (state_q == RB_RESP);
`endif
        req0_ready = accept && !grant_sel;
        req1_ready = accept &&  grant_sel;
        req0_done  = (state_q == DONE) && !cur_grant;
        req1_done  = (state_q == DONE) &&  cur_grant;
        req0_err   = req0_done && cap_err;
        req1_err   = req1_done && cap_err;
        req0_rdata = req0_done ? cap_data : '0;
        req1_rdata = req1_done ? cap_data : '0;
    end

endmodule

// File: tb/tb_red_filter_cfg_sched.sv
// -----------------------------------------------------------------------------
// tb_red_filter_cfg_sched
//
// Directed bench for red_filter_cfg_sched with a small AXI4-Lite slave model
// (four-word memory, optional AWREADY delay, response/B-hold/read-data
// overrides). Each task drives one scenario and checks hand-computed values.
// -----------------------------------------------------------------------------
module tb_red_filter_cfg_sched;

    localparam logic [31:0] BASE = 32'h43C0_0000;
`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
    localparam int WR_LAT = 5;
    localparam bit RB     = 1'b1;
`else
    localparam int WR_LAT = 3;
    localparam bit RB     = 1'b0;
`endif
    localparam int RD_LAT = 3;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;

    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [1:0]  req0_reg = 2'd0;
    logic [31:0] req0_wdata = '0;
    logic        req0_ready, req0_done, req0_err;
    logic [31:0] req0_rdata;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [1:0]  req1_reg = 2'd0;
    logic [31:0] req1_wdata = '0;
    logic        req1_ready, req1_done, req1_err;
    logic [31:0] req1_rdata;

    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 ACLK = ~ACLK;

    red_filter_cfg_sched #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_reg(req0_reg),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_reg(req1_reg),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- AXI4-Lite slave model ----------------
    int          aw_delay = 0;       // cycles AWVALID must wait before AWREADY
    int          aw_wait;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic        b_hold = 1'b0;      // suppress BVALID to park the DUT in WR_RESP
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr_val = '0;
    logic [31:0] mem [4];
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_s, w_data_s, r_data_s, wr_addr, wr_data;
    logic        aw_hs, w_hs, b_hs, r_hs, ar_hs;

    assign M_AXI_AWREADY = (aw_wait >= aw_delay);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_BVALID  = b_pend && !b_hold;
    assign M_AXI_BRESP   = bresp_cfg;
    assign M_AXI_RVALID  = r_pend;
    assign M_AXI_RDATA   = r_data_s;
    assign M_AXI_RRESP   = rresp_cfg;

    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs    = M_AXI_BVALID  && M_AXI_BREADY;
    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs    = M_AXI_RVALID  && M_AXI_RREADY;
    assign wr_addr = aw_hs ? M_AXI_AWADDR : aw_addr_s;
    assign wr_data = w_hs  ? M_AXI_WDATA  : w_data_s;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_wait <= 0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            b_pend  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            if (aw_hs || !M_AXI_AWVALID) aw_wait <= 0;
            else                         aw_wait <= aw_wait + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                mem[wr_addr[3:2]] <= wr_data;
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= M_AXI_AWADDR; end
                if (w_hs)  begin w_got  <= 1'b1; w_data_s  <= M_AXI_WDATA;  end
            end
            if (b_hs) b_pend <= 1'b0;
            if (ar_hs) begin
                r_pend   <= 1'b1;
                r_data_s <= rd_ovr_en ? rd_ovr_val : mem[M_AXI_ARADDR[3:2]];
            end
            if (r_hs) r_pend <= 1'b0;
        end
    end

    // ---------------- Monitors ----------------
    int          cyc = 0, aw_cycles = 0, w_cycles = 0, b_count = 0;
    int          done0_count = 0, done1_count = 0;
    logic [31:0] last_awaddr, last_wdata, last_araddr;
    logic [3:0]  last_wstrb;
    logic [2:0]  last_awprot;

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (M_AXI_AWVALID) aw_cycles <= aw_cycles + 1;
        if (M_AXI_WVALID)  w_cycles  <= w_cycles + 1;
        if (b_hs)          b_count   <= b_count + 1;
        if (req0_done)     done0_count <= done0_count + 1;
        if (req1_done)     done1_count <= done1_count + 1;
        if (aw_hs) begin last_awaddr <= M_AXI_AWADDR; last_awprot <= M_AXI_AWPROT; end
        if (w_hs)  begin last_wdata  <= M_AXI_WDATA;  last_wstrb  <= M_AXI_WSTRB;  end
        if (ar_hs) last_araddr <= M_AXI_ARADDR;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command from requester 'who', starting at a falling edge.
    // acc = accept cycle, lat = done cycle - accept cycle (-1 if never seen).
    // Inputs are scrambled right after acceptance; the DUT must ignore that.
    task automatic do_cmd(input bit who, input bit wr, input logic [1:0] r,
                          input logic [31:0] d, output int acc, output int lat,
                          output logic [31:0] rd, output logic er);
        acc = -1; lat = -1; rd = 'x; er = 1'bx;
        if (!who) begin req0_valid = 1; req0_write = wr; req0_reg = r; req0_wdata = d; end
        else      begin req1_valid = 1; req1_write = wr; req1_reg = r; req1_wdata = d; end
        for (int n = 0; n < 50; n++) begin
            #1;
            if ((!who && req0_ready) || (who && req1_ready)) begin acc = cyc; break; end
            @(negedge ACLK);
        end
        @(negedge ACLK);
        if (!who) begin req0_valid = 0; req0_write = ~wr; req0_reg = ~r; req0_wdata = ~d; end
        else      begin req1_valid = 0; req1_write = ~wr; req1_reg = ~r; req1_wdata = ~d; end
        if (acc < 0) return;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (!who && req0_done) begin lat = cyc - acc; rd = req0_rdata; er = req0_err; break; end
            if (who && req1_done)  begin lat = cyc - acc; rd = req1_rdata; er = req1_err; break; end
            @(negedge ACLK);
        end
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;   // a pending request must not be accepted during reset
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready_gated: got %b expected 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK);
        #1;
        tests_run++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_axi_handshakes: got %b expected 00000",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        tests_run++;
        if ({req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_req_flags: got %b expected 000000",
                     {req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err});
        end
        tests_run++;
        if ({req0_rdata, req1_rdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 0", {req0_rdata, req1_rdata});
        end
        tests_run++;
        if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_data: got %h expected 0", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR});
        end
    endtask

    task automatic test_single_write();
        int acc, lat, d1;
        logic [31:0] rd;
        logic er;
        d1 = done1_count;
        do_cmd(1'b0, 1'b1, 2'd0, 32'h0000_0001, acc, lat, rd, er);
        tests_run++;
        if (lat !== WR_LAT) begin tests_failed++; $display("FAIL single_write_latency: got %0d expected %0d", lat, WR_LAT); end
        tests_run++;
        if (last_awaddr !== BASE) begin tests_failed++; $display("FAIL single_write_awaddr: got %h expected %h", last_awaddr, BASE); end
        tests_run++;
        if (last_wdata !== 32'h1) begin tests_failed++; $display("FAIL single_write_wdata: got %h expected 00000001", last_wdata); end
        tests_run++;
        if ({last_wstrb, last_awprot} !== 7'b1111_000) begin
            tests_failed++;
            $display("FAIL single_write_wstrb_prot: got %b expected 1111000", {last_wstrb, last_awprot});
        end
        tests_run++;
        if (er !== 1'b0) begin tests_failed++; $display("FAIL single_write_err: got %b expected 0", er); end
        tests_run++;
        if (rd !== (RB ? 32'h1 : 32'h0)) begin
            tests_failed++;
            $display("FAIL single_write_rdata: got %h expected %h", rd, (RB ? 32'h1 : 32'h0));
        end
        tests_run++;
        if (done1_count !== d1) begin tests_failed++; $display("FAIL single_write_done_routing: req1 done got %0d expected %0d", done1_count, d1); end
    endtask

    // Writes via req1, reads via req0, each command issued right after the
    // previous done to exercise back-to-back acceptance.
    task automatic test_write_read_all();
        int acc, lat, prev_done;
        logic [31:0] rd, exp_addr;
        logic er;
        prev_done = -1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) do_cmd(1'b1, 1'b1, i[1:0], 32'(i + 1), acc, lat, rd, er);
            else       do_cmd(1'b0, 1'b0, i[1:0], 32'hFFFF_FFFF, acc, lat, rd, er);
            if (prev_done >= 0) begin
                tests_run++;
                if (acc !== prev_done + 1) begin
                    tests_failed++;
                    $display("FAIL back_to_back_accept[%0d]: got cycle %0d expected %0d", i, acc, prev_done + 1);
                end
            end
            prev_done = acc + lat;
            tests_run++;
            if (er !== 1'b0) begin tests_failed++; $display("FAIL wr_rd_err[%0d]: got %b expected 0", i, er); end
            if (i >= 4) begin
                exp_addr = BASE + 32'(4 * (i - 4));
                tests_run++;
                if (lat !== RD_LAT) begin tests_failed++; $display("FAIL read_latency[%0d]: got %0d expected %0d", i, lat, RD_LAT); end
                tests_run++;
                if (rd !== 32'(i - 3)) begin tests_failed++; $display("FAIL read_rdata[%0d]: got %h expected %h", i, rd, 32'(i - 3)); end
                tests_run++;
                if (last_araddr !== exp_addr) begin tests_failed++; $display("FAIL read_araddr[%0d]: got %h expected %h", i, last_araddr, exp_addr); end
            end
        end
    endtask

    task automatic test_handshake_skew();
        int acc, lat, awc, wc, bc, dc;
        logic [31:0] rd;
        logic er;
        aw_delay = 3;
        awc = aw_cycles; wc = w_cycles; bc = b_count; dc = done1_count;
        do_cmd(1'b1, 1'b1, 2'd2, 32'hA5A5_0002, acc, lat, rd, er);
        aw_delay = 0;
        tests_run++;
        if (w_cycles - wc !== 1) begin tests_failed++; $display("FAIL skew_wvalid_cycles: got %0d expected 1", w_cycles - wc); end
        tests_run++;
        if (aw_cycles - awc !== 4) begin tests_failed++; $display("FAIL skew_awvalid_cycles: got %0d expected 4", aw_cycles - awc); end
        tests_run++;
        if (b_count - bc !== 1) begin tests_failed++; $display("FAIL skew_b_count: got %0d expected 1", b_count - bc); end
        tests_run++;
        if (done1_count - dc !== 1) begin tests_failed++; $display("FAIL skew_done_count: got %0d expected 1", done1_count - dc); end
        tests_run++;
        if (lat !== WR_LAT + 3) begin tests_failed++; $display("FAIL skew_latency: got %0d expected %0d", lat, WR_LAT + 3); end
    endtask

    task automatic test_error_resp();
        int acc, lat;
        logic [31:0] rd;
        logic er;
        rresp_cfg = 2'b10;
        do_cmd(1'b0, 1'b0, 2'd2, 32'h0, acc, lat, rd, er);
        rresp_cfg = 2'b00;
        tests_run++;
        if (er !== 1'b1) begin tests_failed++; $display("FAIL read_slverr_err: got %b expected 1", er); end
        tests_run++;
        if (lat !== RD_LAT) begin tests_failed++; $display("FAIL read_slverr_latency: got %0d expected %0d", lat, RD_LAT); end
        do_cmd(1'b0, 1'b0, 2'd2, 32'h0, acc, lat, rd, er);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'hA5A5_0002}) begin
            tests_failed++;
            $display("FAIL read_okay_after_err: got err=%b rdata=%h expected err=0 rdata=a5a50002", er, rd);
        end
        bresp_cfg = 2'b11;
        do_cmd(1'b1, 1'b1, 2'd3, 32'h0000_0033, acc, lat, rd, er);
        bresp_cfg = 2'b00;
        tests_run++;
        if (er !== 1'b1) begin tests_failed++; $display("FAIL write_decerr_err: got %b expected 1", er); end
    endtask

`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
    task automatic test_readback();
        int acc, lat;
        logic [31:0] rd;
        logic er;
        rd_ovr_en = 1'b1;
        rd_ovr_val = 32'hDEAD_BEEF;
        do_cmd(1'b0, 1'b1, 2'd1, 32'h0000_0005, acc, lat, rd, er);
        rd_ovr_en = 1'b0;
        tests_run++;
        if ({er, rd} !== {1'b1, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL readback_mismatch: got err=%b rdata=%h expected err=1 rdata=deadbeef", er, rd);
        end
        tests_run++;
        if (last_araddr !== BASE + 32'h4) begin tests_failed++; $display("FAIL readback_araddr: got %h expected %h", last_araddr, BASE + 32'h4); end
    endtask
`endif

    task automatic test_reset_mid_op();
        int acc, lat, d0;
        bit accepted, in_resp;
        logic [31:0] rd;
        logic er;
        accepted = 0; in_resp = 0;
        b_hold = 1'b1;
        req0_valid = 1; req0_write = 1; req0_reg = 2'd1; req0_wdata = 32'h0000_0077;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req0_ready) begin accepted = 1; break; end
            @(negedge ACLK);
        end
        @(negedge ACLK);
        req0_valid = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (M_AXI_BREADY) begin in_resp = 1; break; end
            @(negedge ACLK);
        end
        tests_run++;
        if ({accepted, in_resp} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midop_reach_wr_resp: got accepted=%b bready=%b expected 1 1", accepted, in_resp);
        end
        @(negedge ACLK);
        d0 = done0_count;
        ARESET = 1'b1;
        @(negedge ACLK);
        #1;
        tests_run++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, req0_done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midop_reset_outputs: got %b expected 000000",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, req0_done});
        end
        ARESET = 1'b0;
        b_hold = 1'b0;
        repeat (4) @(negedge ACLK);
        tests_run++;
        if (done0_count !== d0) begin tests_failed++; $display("FAIL midop_no_done: got %0d dones expected %0d", done0_count, d0); end
        do_cmd(1'b0, 1'b1, 2'd1, 32'h0000_0088, acc, lat, rd, er);
        tests_run++;
        if ({lat, er} !== {WR_LAT, 1'b0}) begin
            tests_failed++;
            $display("FAIL midop_next_write: got lat=%0d err=%b expected lat=%0d err=0", lat, er, WR_LAT);
        end
        do_cmd(1'b1, 1'b0, 2'd1, 32'h0, acc, lat, rd, er);
        tests_run++;
        if (rd !== 32'h0000_0088) begin tests_failed++; $display("FAIL midop_read_back: got %h expected 00000088", rd); end
    endtask

    // Both requesters held valid straight out of reset: grants must go 0,1,0,1.
    task automatic test_simultaneous();
        int grants[4];
        int ng;
        bit both;
        ng = 0; both = 0;
        @(negedge ACLK);
        ARESET = 1'b1;
        req0_valid = 1; req0_write = 1; req0_reg = 2'd0; req0_wdata = 32'h0000_0011;
        req1_valid = 1; req1_write = 0; req1_reg = 2'd3; req1_wdata = 32'h0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        for (int n = 0; n < 60 && ng < 4; n++) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready)      begin grants[ng] = 0; ng++; end
            else if (req1_ready) begin grants[ng] = 1; ng++; end
            @(negedge ACLK);
        end
        req0_valid = 0;
        req1_valid = 0;
        repeat (10) @(negedge ACLK);
        tests_run++;
        if ({both, ng} !== {1'b0, 32'd4}) begin
            tests_failed++;
            $display("FAIL sim_grant_count: got both=%b grants=%0d expected both=0 grants=4", both, ng);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i < ng && grants[i] !== (i % 2)) begin
                tests_failed++;
                $display("FAIL sim_grant_order[%0d]: got req%0d expected req%0d", i, grants[i], i % 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_read_all();
        test_handshake_skew();
        test_error_resp();
`ifdef RED_FILTER_CFG_SCHED_READBACK_EN
        test_readback();
`endif
        test_reset_mid_op();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
